// File: rtl/regbank_pkg.sv
// Shared constants for the UART channel register bank: function codes, response
// byte prefixes, NAK codes and the decode FSM state encoding.
package regbank_pkg;

    localparam logic [7:0] FN_CFG    = 8'h01;
    localparam logic [7:0] FN_CTRL   = 8'h02;
    localparam logic [7:0] FN_COMMIT = 8'h03;
    localparam logic [7:0] FN_EN     = 8'h04;
    localparam logic [7:0] FN_RDBK   = 8'h05;

    localparam logic [3:0] ACK_PFX    = 4'hA;
    localparam logic [3:0] NAK_PFX    = 4'hE;
    localparam logic [3:0] NAK_BAD_CH = 4'h1;
    localparam logic [3:0] NAK_BAD_FN = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_RDBK = 2'd3
    } state_t;

    function automatic logic [7:0] ack_byte(input logic [3:0] fn_lo);
        return {ACK_PFX, fn_lo};
    endfunction

    function automatic logic [7:0] nak_byte(input logic [3:0] code);
        return {NAK_PFX, code};
    endfunction

endpackage

// File: rtl/uart_regbank_ch.sv
// One channel: shadow bank {ctrl,duty,dessert,num,pat}, active copy, pending-commit flag
// and the one-cycle apply strobe. Readback port exists with UART_REGBANK_READBACK_EN.
module uart_regbank_ch
    import regbank_pkg::*;
#(
    parameter int PAT_W = 32
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_duty,
    input  logic [15:0]      cfg_dessert,
    input  logic [7:0]       cfg_num,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             ctrl_we,
    input  logic [7:0]       ctrl_val,
    input  logic             commit_set,
    input  logic             en_we,
    input  logic             en_val,
    input  logic             busy,
    output logic             ch_en,
    output logic [7:0]       duty_num,
    output logic [15:0]      pulse_dessert,
    output logic [7:0]       pulse_num,
    output logic [PAT_W-1:0] pat,
    output logic             apply_stb
`ifdef UART_REGBANK_READBACK_EN
    ,
    output logic [PAT_W+39:0] rb_shadow
`endif
);

    localparam int BANK_W = PAT_W + 40;

    logic [BANK_W-1:0] sh_q, sh_d;
    logic              en_q, en_d;
    logic [7:0]        duty_q, duty_d;
    logic [15:0]       des_q, des_d;
    logic [7:0]        num_q, num_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              pend_q, pend_d;
    logic              stb_q, stb_d;
    logic              apply;

    always_comb begin
        sh_d = sh_q;
        if (cfg_we)  sh_d[PAT_W+31:0] = {cfg_duty, cfg_dessert, cfg_num, cfg_pat};
        if (ctrl_we) sh_d[BANK_W-1 -: 8] = ctrl_val;

        apply  = pend_q && !busy;
        pend_d = commit_set || (pend_q && busy);
        stb_d  = apply;

        en_d   = en_q;
        duty_d = duty_q;
        des_d  = des_q;
        num_d  = num_q;
        pat_d  = pat_q;
        // Apply from sh_d so a shadow write landing on the apply edge is not lost
        if (apply) begin
            {duty_d, des_d, num_d, pat_d} = sh_d[PAT_W+31:0];
            en_d = sh_d[PAT_W+32];
        end
        if (en_we) en_d = en_val;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            en_q   <= 1'b0;
            duty_q <= '0;
            des_q  <= '0;
            num_q  <= '0;
            pat_q  <= '0;
            pend_q <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            en_q   <= en_d;
            duty_q <= duty_d;
            des_q  <= des_d;
            num_q  <= num_d;
            pat_q  <= pat_d;
            pend_q <= pend_d;
            stb_q  <= stb_d;
        end
    end

    assign ch_en         = en_q;
    assign duty_num      = duty_q;
    assign pulse_dessert = des_q;
    assign pulse_num     = num_q;
    assign pat           = pat_q;
    assign apply_stb     = stb_q;
`ifdef UART_REGBANK_READBACK_EN
    assign rb_shadow     = sh_q;
`endif

endmodule

// File: rtl/uart_chan_regbank.sv
// UART command decoder into NUM_CH shadow/active register banks with ACK/NAK response.
// Define UART_REGBANK_READBACK_EN to enable function 0x05 shadow readback (RDBK state).
module uart_chan_regbank
    import regbank_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PAT_W     = 32,
    parameter int PKT_BYTES = 10,
    parameter int ERR_W     = 8
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    pkt_valid,
    input  logic [7:0]              pkt_func,
    input  logic [8*PKT_BYTES-1:0]  pkt_data,
    input  logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [8*NUM_CH-1:0]     duty_num,
    output logic [16*NUM_CH-1:0]    pulse_dessert,
    output logic [8*NUM_CH-1:0]     pulse_num,
    output logic [PAT_W*NUM_CH-1:0] pat,
    output logic [NUM_CH-1:0]       apply_stb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_data,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int PAT_B = PAT_W / 8;

    state_t                 state_q;
    logic [7:0]             func_q;
    logic [8*PKT_BYTES-1:0] data_q;
    logic                   rsp_valid_q;
    logic [7:0]             rsp_data_q;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

    logic [7:0]       b0, b1, b2, b3, b4, b5;
    logic [PAT_W-1:0] pkt_pat;
    logic             exec, ch_ok, nak;
    logic [7:0]       resp_byte;
    logic [1:0]       err_inc;
    logic [ERR_W:0]   err_sum;

    assign b0    = data_q[7:0];
    assign b1    = data_q[15:8];
    assign b2    = data_q[23:16];
    assign b3    = data_q[31:24];
    assign b4    = data_q[39:32];
    assign b5    = data_q[47:40];
    assign exec  = (state_q == ST_EXEC);
    assign ch_ok = (b0 < 8'(NUM_CH));

    always_comb begin
        pkt_pat = '0;
        for (int j = 0; j < PAT_B; j++) begin
            pkt_pat[PAT_W-1-8*j -: 8] = data_q[8*(6+j) +: 8];
        end
    end

`ifdef UART_REGBANK_READBACK_EN
    localparam int RB_W     = PAT_W + 40;
    localparam int RB_BYTES = 5 + PAT_B;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [RB_W-1:0] rb_shadow [NUM_CH];
    logic [RB_W-1:0] rb_sel;
    logic [3:0]      rdbk_idx_q;
    logic [7:0]      rdbk_byte;
    logic            to_rdbk;

    assign rb_sel    = rb_shadow[b0[CH_W-1:0]];
    assign rdbk_byte = rb_sel[RB_W-1-8*rdbk_idx_q -: 8];
`endif

    always_comb begin
        nak       = 1'b0;
        resp_byte = ack_byte(func_q[3:0]);
`ifdef UART_REGBANK_READBACK_EN
        to_rdbk   = 1'b0;
`endif
        case (func_q)
            FN_CFG, FN_CTRL, FN_EN: begin
                if (!ch_ok) begin
                    nak       = 1'b1;
                    resp_byte = nak_byte(NAK_BAD_CH);
                end
            end
            FN_COMMIT: ;
`ifdef UART_REGBANK_READBACK_EN
            FN_RDBK: begin
                if (!ch_ok) begin
                    nak       = 1'b1;
                    resp_byte = nak_byte(NAK_BAD_CH);
                end else begin
                    to_rdbk   = 1'b1;
                end
            end
`endif
            default: begin
                nak       = 1'b1;
                resp_byte = nak_byte(NAK_BAD_FN);
            end
        endcase
    end

    // A NAK and a dropped packet can land on the same edge, so the increment is 0..2
    always_comb begin
        err_inc   = 2'(pkt_valid && (state_q != ST_IDLE)) + 2'(exec && nak);
        err_sum   = {1'b0, err_cnt_q} + (ERR_W+1)'(err_inc);
        err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            func_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef UART_REGBANK_READBACK_EN
            rdbk_idx_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        func_q  <= pkt_func;
                        data_q  <= pkt_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= resp_byte;
`ifdef UART_REGBANK_READBACK_EN
                    rdbk_idx_q  <= '0;
                    state_q     <= to_rdbk ? ST_RDBK : ST_RESP;
`else
                    state_q     <= ST_RESP;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
`ifdef UART_REGBANK_READBACK_EN
                ST_RDBK: begin
                    if (rsp_ready) begin
                        if (rdbk_idx_q == 4'(RB_BYTES)) begin
                            rsp_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rsp_data_q <= rdbk_byte;
                            rdbk_idx_q <= rdbk_idx_q + 4'd1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic hit;
        assign hit = exec && (b0 == 8'(gi));

        uart_regbank_ch #(
            .PAT_W(PAT_W)
        ) u_ch (
            .clk_50M       (clk_50M),
            .rst_n         (rst_n),
            .cfg_we        (hit && (func_q == FN_CFG)),
            .cfg_duty      (b2),
            .cfg_dessert   ({b3, b4}),
            .cfg_num       (b5),
            .cfg_pat       (pkt_pat),
            .ctrl_we       (hit && (func_q == FN_CTRL)),
            .ctrl_val      (b1),
            .commit_set    (exec && (func_q == FN_COMMIT) && b0[gi]),
            .en_we         (hit && (func_q == FN_EN)),
            .en_val        (b1[0]),
            .busy          (ch_busy[gi]),
            .ch_en         (ch_en[gi]),
            .duty_num      (duty_num[8*gi +: 8]),
            .pulse_dessert (pulse_dessert[16*gi +: 16]),
            .pulse_num     (pulse_num[8*gi +: 8]),
            .pat           (pat[PAT_W*gi +: PAT_W]),
            .apply_stb     (apply_stb[gi])
`ifdef UART_REGBANK_READBACK_EN
            ,
            .rb_shadow     (rb_shadow[gi])
`endif
        );
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_chan_regbank.sv
// Directed + randomized check of uart_chan_regbank against a packet-level register model.
module tb_uart_chan_regbank;

    localparam int NUM_CH    = 4;
    localparam int PAT_W     = 32;
    localparam int PKT_BYTES = 10;
    localparam int ERR_W     = 8;

    logic                    clk_50M = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    pkt_valid = 1'b0;
    logic [7:0]              pkt_func = '0;
    logic [8*PKT_BYTES-1:0]  pkt_data = '0;
    logic [NUM_CH-1:0]       ch_busy = '0;
    logic [NUM_CH-1:0]       ch_en;
    logic [8*NUM_CH-1:0]     duty_num;
    logic [16*NUM_CH-1:0]    pulse_dessert;
    logic [8*NUM_CH-1:0]     pulse_num;
    logic [PAT_W*NUM_CH-1:0] pat;
    logic [NUM_CH-1:0]       apply_stb;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic [7:0]              rsp_data;
    logic [ERR_W-1:0]        err_cnt;

    uart_chan_regbank #(
        .NUM_CH(NUM_CH), .PAT_W(PAT_W), .PKT_BYTES(PKT_BYTES), .ERR_W(ERR_W)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_func(pkt_func),
        .pkt_data(pkt_data), .ch_busy(ch_busy), .ch_en(ch_en), .duty_num(duty_num),
        .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .pat(pat),
        .apply_stb(apply_stb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .err_cnt(err_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    int vectors = 0;
    int miscompares = 0;

`define CHK(tag, obs, exp) \
    begin \
        vectors++; \
        assert ((obs) === (exp)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

    // Packet-level model: shadow and active banks per channel, error count
    logic [7:0]        m_sh_ctrl [NUM_CH];
    logic [7:0]        m_sh_duty [NUM_CH];
    logic [15:0]       m_sh_des  [NUM_CH];
    logic [7:0]        m_sh_num  [NUM_CH];
    logic [31:0]       m_sh_pat  [NUM_CH];
    logic [7:0]        m_duty    [NUM_CH];
    logic [15:0]       m_des     [NUM_CH];
    logic [7:0]        m_num     [NUM_CH];
    logic [31:0]       m_pat     [NUM_CH];
    logic [NUM_CH-1:0] m_en;
    logic [7:0]        m_err;

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh_ctrl[i] = '0; m_sh_duty[i] = '0; m_sh_des[i] = '0; m_sh_num[i] = '0; m_sh_pat[i] = '0;
            m_duty[i] = '0; m_des[i] = '0; m_num[i] = '0; m_pat[i] = '0;
        end
        m_en  = '0;
        m_err = '0;
    endtask

    function automatic logic [7:0] model_rsp(input logic [7:0] f, input logic [7:0] c);
        if (f == 8'h01 || f == 8'h02 || f == 8'h04)
            return (int'(c) < NUM_CH) ? (8'hA0 | f) : 8'hE1;
        if (f == 8'h03) return 8'hA3;
`ifdef UART_REGBANK_READBACK_EN
        if (f == 8'h05) return (int'(c) < NUM_CH) ? 8'hA5 : 8'hE1;
`endif
        return 8'hE2;
    endfunction

    task automatic model_exec(input logic [7:0] f, input logic [79:0] d, output logic [3:0] cm);
        logic [7:0] r;
        int c;
        r  = model_rsp(f, d[7:0]);
        c  = int'(d[7:0]);
        cm = '0;
        if (r[7:4] == 4'hE) begin
            m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
        end else begin
            case (f)
                8'h01: begin
                    m_sh_duty[c] = d[23:16];
                    m_sh_des[c]  = {d[31:24], d[39:32]};
                    m_sh_num[c]  = d[47:40];
                    m_sh_pat[c]  = {d[55:48], d[63:56], d[71:64], d[79:72]};
                end
                8'h02: m_sh_ctrl[c] = d[15:8];
                8'h03: cm = d[3:0];
                8'h04: m_en[c] = d[8];
                default: ;
            endcase
        end
    endtask

    task automatic model_apply(input logic [3:0] m);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                m_duty[i] = m_sh_duty[i];
                m_des[i]  = m_sh_des[i];
                m_num[i]  = m_sh_num[i];
                m_pat[i]  = m_sh_pat[i];
                m_en[i]   = m_sh_ctrl[i][0];
            end
        end
    endtask

    task automatic check_active();
        `CHK("ch_en", ch_en, m_en)
        for (int i = 0; i < NUM_CH; i++) begin
            `CHK("duty_num", duty_num[8*i +: 8], m_duty[i])
            `CHK("pulse_dessert", pulse_dessert[16*i +: 16], m_des[i])
            `CHK("pulse_num", pulse_num[8*i +: 8], m_num[i])
            `CHK("pat", pat[32*i +: 32], m_pat[i])
        end
    endtask

    // Pulse one packet and wait (bounded) for the response; got = first response byte
    task automatic send(input logic [7:0] f, input logic [79:0] d, output logic [7:0] got);
        int n;
        pkt_func  = f;
        pkt_data  = d;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 8) begin
            step();
            n++;
        end
        `CHK("rsp_latency", n, 1)
        got = rsp_data;
    endtask

    task automatic do_pkt(input logic [7:0] f, input logic [79:0] d, input logic [3:0] busy, input int hold);
        logic [7:0] got, exp;
        logic [3:0] cm;
        ch_busy = busy;
        exp = model_rsp(f, d[7:0]);
        send(f, d, got);
        `CHK("rsp_data", got, exp)
        model_exec(f, d, cm);
        step();
        `CHK("rsp_done", rsp_valid, 1'b0)
        `CHK("apply_stb", apply_stb, cm & ~busy)
        model_apply(cm & ~busy);
        check_active();
        `CHK("err_cnt", err_cnt, m_err)
        if ((cm & busy) != 4'b0) begin
            for (int k = 0; k < hold; k++) begin
                step();
                `CHK("busy_hold_stb", apply_stb, 4'b0)
            end
            check_active();
            ch_busy = '0;
            step();
            `CHK("busy_release_stb", apply_stb, cm & busy)
            model_apply(cm & busy);
            check_active();
        end
        ch_busy = '0;
        step();
        `CHK("stb_pulse_end", apply_stb, 4'b0)
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got, f;
        logic [79:0] d;
        logic [3:0]  busy;

        model_reset();
        rst_n = 1'b0;
        repeat (3) step();
        `CHK("reset_rsp_valid", rsp_valid, 1'b0)
        `CHK("reset_rsp_data", rsp_data, 8'h00)
        `CHK("reset_err_cnt", err_cnt, m_err)
        `CHK("reset_apply_stb", apply_stb, 4'b0)
        check_active();
        rst_n = 1'b1;
        step();

        // Config ch1, then commit mask 0x02
        do_pkt(8'h01, 80'hEFBEADDE_03100005_0001, 4'b0, 3);
        do_pkt(8'h03, 80'h02, 4'b0, 3);
        `CHK("t1_pat1", pat[63:32], 32'hDEADBEEF)
        `CHK("t1_dessert1", pulse_dessert[31:16], 16'h0010)
        `CHK("t1_duty1", duty_num[15:8], 8'h05)
        `CHK("t1_num1", pulse_num[15:8], 8'h03)

`ifdef UART_REGBANK_READBACK_EN
        begin
            logic [7:0] rb_exp [10];
            rb_exp = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h10, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
            send(8'h05, 80'h01, got);
            `CHK("rdbk_byte", got, rb_exp[0])
            for (int k = 1; k < 10; k++) begin
                step();
                `CHK("rdbk_valid", rsp_valid, 1'b1)
                `CHK("rdbk_byte", rsp_data, rb_exp[k])
            end
            step();
            `CHK("rdbk_done", rsp_valid, 1'b0)
        end
`endif

        // Busy channel holds the commit for 20 cycles
        do_pkt(8'h01, 80'h78563412_07CDAB09_0001, 4'b0, 3);
        do_pkt(8'h03, 80'h02, 4'b0010, 20);
        `CHK("t2_pat1", pat[63:32], 32'h12345678)

        // Bad channel and unknown function
        do_pkt(8'h01, 80'h07, 4'b0, 3);
        `CHK("t3_err1", err_cnt, 8'd1)
        do_pkt(8'h09, 80'h01, 4'b0, 3);
        `CHK("t3_err2", err_cnt, 8'd2)

        // Response held off; a packet arriving in RESP is dropped
        rsp_ready = 1'b0;
        send(8'h02, 80'h0100, got);
        `CHK("t4_rsp", got, 8'hA2)
        model_exec(8'h02, 80'h0100, busy);
        for (int k = 0; k < 6; k++) begin
            `CHK("t4_hold_valid", rsp_valid, 1'b1)
            `CHK("t4_hold_data", rsp_data, 8'hA2)
            if (k == 2) begin
                pkt_func  = 8'h04;
                pkt_data  = 80'h0100;
                pkt_valid = 1'b1;
                m_err     = m_err + 8'd1;
            end
            step();
            pkt_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        `CHK("t4_rsp_done", rsp_valid, 1'b0)
        `CHK("t4_err", err_cnt, m_err)
        repeat (3) step();
        `CHK("t4_no_second_rsp", rsp_valid, 1'b0)
        check_active();

        // Immediate enable bypasses shadow and pend
        do_pkt(8'h04, 80'h0102, 4'b0, 3);
        `CHK("t5_en2", ch_en[2], 1'b1)

        // Shadow rewritten while commit pending: newest value applies
        ch_busy = 4'b1000;
        send(8'h03, 80'h08, got);
        `CHK("newest_commit_rsp", got, 8'hA3)
        step();
        `CHK("newest_pending_stb", apply_stb, 4'b0)
        d = 80'hCAFEF00D_11223344_0103;
        send(8'h01, d, got);
        `CHK("newest_cfg_rsp", got, 8'hA1)
        model_exec(8'h01, d, busy);
        step();
        ch_busy = 4'b0;
        step();
        `CHK("newest_apply_stb", apply_stb, 4'b1000)
        model_apply(4'b1000);
        check_active();
        step();

        // Randomized packets
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 5))
                0: f = 8'h01;
                1: f = 8'h02;
                2: f = 8'h03;
                3: f = 8'h04;
                4: f = 8'h01;
                default: f = 8'($urandom_range(5, 255));
            endcase
`ifdef UART_REGBANK_READBACK_EN
            if (f == 8'h05) f = 8'h06;
`endif
            d = {16'($urandom), $urandom, $urandom};
            d[7:0] = (f == 8'h03) ? 8'($urandom) : 8'($urandom_range(0, 7));
            busy = 4'($urandom_range(0, 15));
            do_pkt(f, d, busy, 3);
        end

        // Reset while a response is outstanding and commits are pending
        rsp_ready = 1'b0;
        ch_busy   = 4'hF;
        send(8'h03, 80'h0F, got);
        `CHK("midrst_rsp", got, 8'hA3)
        rst_n = 1'b0;
        #5;
        model_reset();
        `CHK("midrst_valid", rsp_valid, 1'b0)
        `CHK("midrst_err", err_cnt, m_err)
        check_active();
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        ch_busy   = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            `CHK("midrst_no_apply", apply_stb, 4'b0)
            `CHK("midrst_no_rsp", rsp_valid, 1'b0)
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
